event_readout_sequencer: RTL and testbench

- Consumer stage for the trigger interface's event buffers, in the 33 MHz domain.
- When a buffered event is pending, it walks the event's header words through the event read port.
- It presents those words as a valid/ready word stream with an end-of-event marker toward the host readout path.
- It then pulses the clear-event strobe and waits a fixed holdoff so the cross-domain buffer status settles before the next event is considered.

---
 rtl/event_readout_sequencer_pkg.sv | 26 ++
 rtl/event_readout_sequencer_holdoff_counter.sv | 46 ++++
 rtl/event_readout_sequencer.sv | 136 +++++++++++++
 tb/tb_event_readout_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_readout_sequencer_pkg.sv
// Shared trigger/readout definitions: sequencer state encoding and event RAM addressing layout.
package event_readout_sequencer_pkg;

    localparam int EVT_ADDR_WIDTH     = 6;
    localparam int EVT_WORD_IDX_WIDTH = 4;
    localparam int EVT_HDR_WORDS      = 8;
    localparam int EVT_BUF_WIDTH      = EVT_ADDR_WIDTH - EVT_WORD_IDX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_HOLDOFF = 3'd5
    } seq_state_e;

    // Event RAM address: buffer select in the upper bits, header word index below.
    function automatic logic [EVT_ADDR_WIDTH-1:0] evt_addr(
        input logic [EVT_BUF_WIDTH-1:0]      buf_sel,
        input logic [EVT_WORD_IDX_WIDTH-1:0] word_idx
    );
        return {buf_sel, word_idx};
    endfunction

endpackage

// File: rtl/event_readout_sequencer_holdoff_counter.sv
// Loadable down-counter with a registered done flag, used to time settle waits after
// cross-domain status changes.
module readout_holdoff_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_next_s;
    logic             done_r;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        cnt_next_s = cnt_r;
        if (load) begin
            cnt_next_s = load_val;
        end else if (cnt_r != {WIDTH{1'b0}}) begin
            cnt_next_s = cnt_r - WIDTH'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register; done tracks the registered count reaching zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {WIDTH{1'b0}};
            done_r <= 1'b1;
        end else if (srst) begin
            cnt_r  <= {WIDTH{1'b0}};
            done_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_next_s;
            done_r <= (cnt_next_s == {WIDTH{1'b0}});
        end
    end

    assign done = done_r;

endmodule

// File: rtl/event_readout_sequencer.sv
// Reads buffered event headers from the event RAM, streams them downstream with an
// end-of-event marker, then releases the buffer and waits for its status to settle.
module event_readout_sequencer
    import event_readout_sequencer_pkg::*;
#(
    parameter int NUM_WORDS   = EVT_HDR_WORDS,
    parameter int CLR_HOLDOFF = 6,
    parameter int EVCNT_WIDTH = 16
) (
    input  logic                      clk33_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic                      event_ready_i,
    input  logic [EVT_BUF_WIDTH-1:0]  rd_buf_i,
    output logic [EVT_ADDR_WIDTH-1:0] event_addr_o,
    input  logic [31:0]               event_dat_i,
    output logic [31:0]               dat_o,
    output logic                      valid_o,
    output logic                      last_o,
    input  logic                      ready_i,
    output logic                      clr_evt_o,
    output logic                      busy_o,
    output logic [EVCNT_WIDTH-1:0]    evt_count_o
);

    localparam int HO_WIDTH = (CLR_HOLDOFF > 1) ? $clog2(CLR_HOLDOFF) : 1;
    localparam logic [EVT_WORD_IDX_WIDTH-1:0] LAST_IDX = EVT_WORD_IDX_WIDTH'(NUM_WORDS - 1);
    localparam logic [HO_WIDTH-1:0]           HO_LOAD  = HO_WIDTH'(CLR_HOLDOFF - 1);

    seq_state_e                    state_r;
    logic [EVT_WORD_IDX_WIDTH-1:0] idx_r;
    logic [EVT_BUF_WIDTH-1:0]      rd_buf_r;
    logic [EVT_ADDR_WIDTH-1:0]     addr_r;
    logic [31:0]                   dat_r;
    logic                          valid_r;
    logic                          last_r;
    logic                          clr_r;
    logic                          busy_r;
    logic [EVCNT_WIDTH-1:0]        evt_count_r;
    logic                          ho_load_s;
    logic                          ho_done_s;

    // Loaded during CLEAR so HOLDOFF spans exactly CLR_HOLDOFF cycles.
    assign ho_load_s = (state_r == ST_CLEAR);

    readout_holdoff_counter #(
        .WIDTH (HO_WIDTH)
    ) u_holdoff (
        .clk      (clk33_i),
        .rst_n    (rst_n_i),
        .srst     (1'b0),
        .load     (ho_load_s),
        .load_val (HO_LOAD),
        .done     (ho_done_s)
    );

    // Sequencer FSM; the RAM address is updated on entry to FETCH so it is stable
    // for the whole fetch and stays frozen while a word waits for its handshake.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            idx_r       <= {EVT_WORD_IDX_WIDTH{1'b0}};
            rd_buf_r    <= {EVT_BUF_WIDTH{1'b0}};
            addr_r      <= {EVT_ADDR_WIDTH{1'b0}};
            dat_r       <= 32'd0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            clr_r       <= 1'b0;
            busy_r      <= 1'b0;
            evt_count_r <= {EVCNT_WIDTH{1'b0}};
        end else begin
            clr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enable_i && event_ready_i) begin
                        rd_buf_r <= rd_buf_i;
                        idx_r    <= {EVT_WORD_IDX_WIDTH{1'b0}};
                        addr_r   <= evt_addr(rd_buf_i, {EVT_WORD_IDX_WIDTH{1'b0}});
                        busy_r   <= 1'b1;
                        state_r  <= ST_FETCH;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    dat_r   <= event_dat_i;
                    valid_r <= 1'b1;
                    last_r  <= (idx_r == LAST_IDX);
                    state_r <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            clr_r       <= 1'b1;
                            evt_count_r <= evt_count_r + EVCNT_WIDTH'(1);
                            state_r     <= ST_CLEAR;
                        end else begin
                            idx_r   <= idx_r + EVT_WORD_IDX_WIDTH'(1);
                            addr_r  <= evt_addr(rd_buf_r, idx_r + EVT_WORD_IDX_WIDTH'(1));
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_r <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (ho_done_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign event_addr_o = addr_r;
    assign dat_o        = dat_r;
    assign valid_o      = valid_r;
    assign last_o       = last_r;
    assign clr_evt_o    = clr_r;
    assign busy_o       = busy_r;
    assign evt_count_o  = evt_count_r;

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Directed bench for event_readout_sequencer: registered-RAM model, stream monitor and
// hand-computed cycle timings for the default and a narrow-counter single-word instance.
module tb_event_readout_sequencer;

    logic        clk33;
    logic        rst_n;
    logic        enable;
    logic        event_ready;
    logic [1:0]  rd_buf;
    logic [5:0]  event_addr;
    logic [31:0] ram_q;
    logic [31:0] dat;
    logic        valid;
    logic        last;
    logic        ready;
    logic        clr_evt;
    logic        busy;
    logic [15:0] evt_count;

    logic        event_ready_w;
    logic [5:0]  addr_w;
    logic [31:0] dat_w;
    logic        valid_w;
    logic        last_w;
    logic        clr_w;
    logic        busy_w;
    logic [1:0]  cnt_w;

    logic [31:0] mem [0:63];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // monitor state
    logic [1:0]  exp_buf = 2'b00;
    int          exp_idx = 0;
    int          word_total = 0;
    int          clr_total = 0;
    int          first_hs_cyc = 0;
    int          last_hs_cyc = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_dat;
    logic [5:0]  prev_addr;
    logic        prev_last;

    event_readout_sequencer dut (
        .clk33_i       (clk33),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .event_ready_i (event_ready),
        .rd_buf_i      (rd_buf),
        .event_addr_o  (event_addr),
        .event_dat_i   (ram_q),
        .dat_o         (dat),
        .valid_o       (valid),
        .last_o        (last),
        .ready_i       (ready),
        .clr_evt_o     (clr_evt),
        .busy_o        (busy),
        .evt_count_o   (evt_count)
    );

    event_readout_sequencer #(
        .NUM_WORDS   (1),
        .CLR_HOLDOFF (1),
        .EVCNT_WIDTH (2)
    ) u_wrap (
        .clk33_i       (clk33),
        .rst_n_i       (rst_n),
        .enable_i      (1'b1),
        .event_ready_i (event_ready_w),
        .rd_buf_i      (2'b00),
        .event_addr_o  (addr_w),
        .event_dat_i   (32'hC0DE_0001),
        .dat_o         (dat_w),
        .valid_o       (valid_w),
        .last_o        (last_w),
        .ready_i       (1'b1),
        .clr_evt_o     (clr_w),
        .busy_o        (busy_w),
        .evt_count_o   (cnt_w)
    );

    function automatic logic [31:0] exp_word(input logic [1:0] b, input logic [3:0] n);
        return 32'hA5A5_0000 + {22'd0, b ^ 2'b10, 4'd0, n};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial clk33 = 1'b0;
    always #15 clk33 = ~clk33;

    always @(posedge clk33) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = 6'(i);
            mem[i] = exp_word(a[5:4], a[3:0]);
        end
    end

    // registered RAM: data follows the address by one clock
    always @(posedge clk33) ram_q <= mem[event_addr];

    // stream monitor: word order, address, last marker, stability under backpressure
    always @(negedge clk33) begin
        #1;
        if (!rst_n) begin
            exp_idx   = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", valid, 1);
                check_eq("hold_dat", dat, prev_dat);
                check_eq("hold_addr", event_addr, prev_addr);
                check_eq("hold_last", last, prev_last);
            end
            if (clr_evt) begin
                clr_total++;
                check_eq("clr_after_last", cyc, last_hs_cyc + 1);
            end
            if (valid && ready) begin
                if (exp_idx == 0) first_hs_cyc = cyc;
                check_eq("word_dat", dat, exp_word(exp_buf, 4'(exp_idx)));
                check_eq("word_addr", event_addr, {exp_buf, 4'(exp_idx)});
                check_eq("word_last", last, (exp_idx == 7) ? 1 : 0);
                last_hs_cyc = cyc;
                word_total++;
                exp_idx   = (exp_idx == 7) ? 0 : exp_idx + 1;
                prev_hold = 1'b0;
            end else if (valid) begin
                prev_hold = 1'b1;
                prev_dat  = dat;
                prev_addr = event_addr;
                prev_last = last;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic start_evt(input logic [1:0] b, output int k0);
        @(negedge clk33);
        enable      = 1'b1;
        event_ready = 1'b1;
        rd_buf      = b;
        exp_buf     = b;
        k0          = cyc + 1;
    endtask

    task automatic wait_clr(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk33);
            #1;
            n++;
        end while (!clr_evt && n < 200);
        check_eq("clr_seen", clr_evt, 1);
        c = cyc;
    endtask

    task automatic wait_idle(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk33);
            #1;
            n++;
        end while (busy && n < 200);
        check_eq("idle_seen", busy, 0);
        c = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k2, c, c1, c2, b, w0, cl0, n;
        rst_n = 1'b0; enable = 1'b0; event_ready = 1'b0; rd_buf = 2'b00;
        ready = 1'b1; event_ready_w = 1'b0;

        repeat (3) @(negedge clk33);
        #1;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr", event_addr, 0);
        check_eq("rst_dat", dat, 0);
        check_eq("rst_last", last, 0);
        check_eq("rst_clr", clr_evt, 0);
        check_eq("rst_count", evt_count, 0);

        // enable low: event pending but nothing starts
        @(negedge clk33);
        rst_n = 1'b1;
        event_ready = 1'b1;
        repeat (8) @(negedge clk33);
        #1;
        check_eq("dis_busy", busy, 0);
        check_eq("dis_addr", event_addr, 0);
        check_eq("dis_valid", valid, 0);

        // single event, ready held high
        w0 = word_total; cl0 = clr_total;
        start_evt(2'b10, k0);
        @(negedge clk33);
        event_ready = 1'b0;
        rd_buf = 2'b00;
        wait_clr(c);
        check_eq("t1_clr_time", c, k0 + 24);
        check_eq("t1_count_at_clr", evt_count, 1);
        wait_idle(b);
        check_eq("t1_busy_low", b, c + 7);
        check_eq("t1_first_valid", first_hs_cyc, k0 + 2);
        check_eq("t1_words", word_total - w0, 8);
        check_eq("t1_clrs", clr_total - cl0, 1);

        // backpressure on word 3 for 5 cycles
        w0 = word_total;
        start_evt(2'b01, k0);
        @(negedge clk33);
        event_ready = 1'b0;
        rd_buf = 2'b11;
        while (cyc != k0 + 11) @(negedge clk33);
        ready = 1'b0;
        while (cyc != k0 + 16) @(negedge clk33);
        ready = 1'b1;
        wait_clr(c);
        check_eq("t2_clr_time", c, k0 + 29);
        wait_idle(b);
        check_eq("t2_words", word_total - w0, 8);
        check_eq("t2_count", evt_count, 2);

        // two back-to-back events with event_ready held
        w0 = word_total; cl0 = clr_total;
        start_evt(2'b11, k0);
        @(negedge clk33);
        rd_buf = 2'b00;
        wait_clr(c1);
        exp_buf = 2'b00;
        wait_idle(b);
        n = 0;
        do begin
            @(negedge clk33);
            #1;
            n++;
        end while (!busy && n < 50);
        check_eq("t3_restart", busy, 1);
        k2 = cyc;
        check_eq("t3_gap", k2 - c1, 8);
        event_ready = 1'b0;
        wait_clr(c2);
        check_eq("t3_clr2_time", c2, k2 + 24);
        wait_idle(b);
        check_eq("t3_clrs", clr_total - cl0, 2);
        check_eq("t3_words", word_total - w0, 16);
        check_eq("t3_count", evt_count, 4);

        // enable dropped on word 2: event completes, then stays idle
        w0 = word_total;
        start_evt(2'b01, k0);
        @(negedge clk33);
        rd_buf = 2'b10;
        while (cyc != k0 + 7) @(negedge clk33);
        enable = 1'b0;
        wait_clr(c);
        check_eq("t4_clr_time", c, k0 + 24);
        wait_idle(b);
        repeat (10) @(negedge clk33);
        #1;
        check_eq("t4_stay_idle", busy, 0);
        check_eq("t4_addr_hold", event_addr, 6'h17);
        check_eq("t4_words", word_total - w0, 8);
        check_eq("t4_count", evt_count, 5);

        // async reset while word 4 is stalled in PRESENT
        cl0 = clr_total;
        start_evt(2'b10, k0);
        @(negedge clk33);
        while (cyc != k0 + 13) @(negedge clk33);
        ready = 1'b0;
        while (cyc != k0 + 16) @(negedge clk33);
        rst_n = 1'b0;
        #1;
        check_eq("t5_valid", valid, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_addr", event_addr, 0);
        check_eq("t5_dat", dat, 0);
        check_eq("t5_last", last, 0);
        check_eq("t5_clr", clr_evt, 0);
        check_eq("t5_count", evt_count, 0);
        @(negedge clk33);
        rst_n = 1'b1;
        ready = 1'b1;
        w0 = word_total;
        wait_clr(c);
        event_ready = 1'b0;
        wait_idle(b);
        check_eq("t5_words", word_total - w0, 8);
        check_eq("t5_clrs", clr_total - cl0, 1);
        check_eq("t5_count_after", evt_count, 1);

        // single-word events on the 2-bit counter instance: wrap 3 -> 0
        @(negedge clk33);
        event_ready_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk33);
                #1;
                n++;
                if (valid_w) begin
                    check_eq("w1_last", last_w, 1);
                    check_eq("w1_dat", dat_w, 32'hC0DE_0001);
                end
            end while (!clr_w && n < 50);
            check_eq("wrap_clr", clr_w, 1);
            check_eq("wrap_cnt", cnt_w, 32'((i + 1) % 4));
            if (i == 3) event_ready_w = 1'b0;
        end

        repeat (4) @(negedge clk33);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
